// File: rtl/wb_cmd_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_cmd_master: valid/ready command stream to single-beat classic Wishbone.  |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module wb_cmd_master #(
    parameter int c_DATA_WIDTH = 64,
    parameter int MAX_RETRY    = 3,
    parameter int BACKOFF      = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [31:0]             cmd_adr,
    input  logic [7:0]              cmd_sel,
    input  logic [c_DATA_WIDTH-1:0] cmd_dat,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [c_DATA_WIDTH-1:0] rsp_dat,
    output logic [1:0]              rsp_status,
    output logic [31:0]             m_adr_o,
    output logic [c_DATA_WIDTH-1:0] m_dat_o,
    output logic [7:0]              m_sel_o,
    output logic [2:0]              m_cti_o,
    output logic                    m_we_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    input  logic [c_DATA_WIDTH-1:0] m_dat_i,
    input  logic                    m_ack_i,
    input  logic                    m_err_i,
    input  logic                    m_rty_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_ERR     = 2'b01;
    localparam logic [1:0] c_ST_RTY_EXH = 2'b10;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b11;

    localparam logic [15:0] c_RETRY_MAX    = 16'(MAX_RETRY);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_BACKOFF_LAST = 16'(BACKOFF - 1);
    localparam logic        c_TIMEOUT_EN   = (TIMEOUT != 0);

    logic [2:0]              r_state;
    logic [2:0]              w_next;
    logic [1:0]              w_status;
    logic [15:0]             r_cnt;
    logic [15:0]             r_retry;
    logic                    w_retry_ok;
    logic                    w_timeout;
    logic                    r_cyc;
    logic                    r_rsp_valid;
    logic [1:0]              r_rsp_status;
    logic [c_DATA_WIDTH-1:0] r_rsp_dat;
    logic [31:0]             r_adr;
    logic [c_DATA_WIDTH-1:0] r_dat;
    logic [7:0]              r_sel;
    logic                    r_we;

    // r_cnt is the ACCESS wait count and the BACKOFF idle count; it restarts on every state change
    assign w_retry_ok = (r_retry < c_RETRY_MAX);
    assign w_timeout  = c_TIMEOUT_EN && (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_status = c_ST_OK;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_ack_i) begin
                    w_next = S_RESP;
                end else if (m_err_i) begin
                    w_next   = S_RESP;
                    w_status = c_ST_ERR;
                end else if (m_rty_i) begin
                    if (w_retry_ok) begin
                        w_next = S_BACKOFF;
                    end else begin
                        w_next   = S_RESP;
                        w_status = c_ST_RTY_EXH;
                    end
                end else if (w_timeout) begin
                    w_next   = S_RESP;
                    w_status = c_ST_TIMEOUT;
                end
            end
            S_BACKOFF: begin
                if (r_cnt == c_BACKOFF_LAST) begin
                    w_next = S_ACCESS;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so cyc/stb drop on the sampling edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cyc        <= 1'b0;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_dat    <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
        end else begin
            r_cyc <= (w_next == S_ACCESS);
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_adr   <= cmd_adr;
                r_dat   <= cmd_dat;
                r_sel   <= cmd_sel;
                r_we    <= cmd_we;
                r_retry <= '0;
            end
            if ((r_state == S_ACCESS) && (w_next == S_BACKOFF)) begin
                r_retry <= r_retry + 16'd1;
            end
            if ((r_state == S_ACCESS) && (w_next == S_RESP)) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_status <= w_status;
                r_rsp_dat    <= (m_ack_i && !r_we) ? m_dat_i : '0;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;
    assign m_adr_o    = r_adr;
    assign m_dat_o    = r_dat;
    assign m_sel_o    = r_sel;
    assign m_we_o     = r_we;
    assign m_cyc_o    = r_cyc;
    assign m_stb_o    = r_cyc;
    assign m_cti_o    = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_wb_cmd_master: directed vector bench for wb_cmd_master.                  |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module tb_wb_cmd_master;

    localparam int DW   = 64;
    localparam int BOFF = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [31:0]   cmd_adr = '0;
    logic [7:0]    cmd_sel = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic [31:0]   m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic [7:0]    m_sel_o;
    logic [2:0]    m_cti_o;
    logic          m_we_o;
    logic          m_cyc_o;
    logic          m_stb_o;
    logic [DW-1:0] m_dat_i = '0;
    logic          m_ack_i = 1'b0;
    logic          m_err_i = 1'b0;
    logic          m_rty_i = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .c_DATA_WIDTH(DW),
        .MAX_RETRY   (3),
        .BACKOFF     (BOFF),
        .TIMEOUT     (1024)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_sel   (cmd_sel),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_sel_o   (m_sel_o),
        .m_cti_o   (m_cti_o),
        .m_we_o    (m_we_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .m_err_i   (m_err_i),
        .m_rty_i   (m_rty_i)
    );

    // fin: 0 ack, 1 err, 2 rty, 3 no response; the first n_rty attempts always answer rty
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] wdat;
        int          n_rty;
        int          fin;
        int          delay;
        logic [63:0] rdat;
        logic [1:0]  exp_st;
        logic [63:0] exp_dat;
        int          exp_cyc;
        int          exp_att;
        int          hold;
        logic        late_ack;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_txn(input vec_t v);
        int   att, idx, cyc_cnt, gap, gap_bad, bus_bad, hold_bad, cycles;
        logic prev;
        @(negedge clk);
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_sel   = v.sel;
        cmd_dat   = v.wdat;
        cmd_valid = 1'b1;
        m_dat_i   = v.rdat;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("setup_cyc", 64'(m_cyc_o), 64'd0);
        check("setup_adr", 64'(m_adr_o), 64'(v.adr));
        att = 0; idx = 0; cyc_cnt = 0; gap = 0; gap_bad = 0; bus_bad = 0; cycles = 0; prev = 1'b0;
        while (!rsp_valid && cycles < 5000) begin
            m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
            if (m_adr_o !== v.adr || m_sel_o !== v.sel || m_we_o !== v.we ||
                m_stb_o !== m_cyc_o || m_cti_o !== 3'b000) bus_bad++;
            if (v.we && m_dat_o !== v.wdat) bus_bad++;
            if (m_cyc_o) begin
                if (!prev) begin
                    att++;
                    idx = 0;
                    if (att > 1 && gap != BOFF) gap_bad++;
                end
                idx++;
                cyc_cnt++;
                if (idx == v.delay) begin
                    if (att <= v.n_rty) m_rty_i = 1'b1;
                    else if (v.fin == 0) m_ack_i = 1'b1;
                    else if (v.fin == 1) m_err_i = 1'b1;
                    else if (v.fin == 2) m_rty_i = 1'b1;
                end
            end else if (att > 0) begin
                if (prev) gap = 0;
                gap++;
            end
            prev = m_cyc_o;
            cycles++;
            @(negedge clk);
        end
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
        check("rsp_in_budget", 64'(rsp_valid), 64'd1);
        check("rsp_status", 64'(rsp_status), 64'(v.exp_st));
        check("rsp_dat", rsp_dat, v.exp_dat);
        check("cyc_cycles", 64'(cyc_cnt), 64'(v.exp_cyc));
        check("attempts", 64'(att), 64'(v.exp_att));
        check("backoff_gaps", 64'(gap_bad), 64'd0);
        check("bus_stable", 64'(bus_bad), 64'd0);
        hold_bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            m_ack_i = v.late_ack && (h == 1);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || m_cyc_o !== 1'b0 ||
                rsp_status !== v.exp_st || rsp_dat !== v.exp_dat) hold_bad++;
            @(negedge clk);
        end
        m_ack_i = 1'b0;
        check("rsp_held", 64'(hold_bad), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_bad;
        vecs[0] = '{1'b0, 32'h0000_2000, 8'hFF, 64'h0, 0, 0, 3, 64'h1122_3344_5566_7788,
                    2'b00, 64'h1122_3344_5566_7788, 3, 1, 0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_1008, 8'h0F, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1, 1, 64'h0123_4567_89AB_CDEF,
                    2'b01, 64'h0, 1, 1, 0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_3000, 8'hF0, 64'h0, 3, 0, 2, 64'h0FED_CBA9_8765_4321,
                    2'b00, 64'h0FED_CBA9_8765_4321, 8, 4, 0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_3008, 8'hFF, 64'h0, 3, 2, 1, 64'h1,
                    2'b10, 64'h0, 4, 4, 0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_4000, 8'hFF, 64'h0, 0, 3, 0, 64'hDEAD_BEEF_0000_0001,
                    2'b11, 64'h0, 1024, 1, 3, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_4008, 8'h80, 64'h1234_0000_5678_9ABC, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                    2'b00, 64'h0, 1, 1, 2, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_7000, 8'h01, 64'h0, 1, 1, 2, 64'h5555,
                    2'b01, 64'h0, 4, 2, 0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", 64'(m_cyc_o), 64'd0);
        check("rst_stb", 64'(m_stb_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_adr", 64'(m_adr_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Response back-pressure with a queued command
        @(negedge clk);
        cmd_we = 1'b0; cmd_adr = 32'h0000_5000; cmd_sel = 8'hFF; cmd_dat = '0; cmd_valid = 1'b1;
        m_dat_i = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        cmd_adr = 32'h0000_5100; cmd_sel = 8'h3C;
        check("q_setup_adr", 64'(m_adr_o), 64'h5000);
        @(negedge clk);
        check("q_access_cyc", 64'(m_cyc_o), 64'd1);
        m_ack_i = 1'b1;
        @(negedge clk);
        m_ack_i = 1'b0;
        hold_bad = 0;
        for (int h = 0; h < 5; h++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || m_adr_o !== 32'h0000_5000 ||
                rsp_dat !== 64'hCAFE_F00D_1234_5678 || rsp_status !== 2'b00) hold_bad++;
            @(negedge clk);
        end
        check("q_hold", 64'(hold_bad), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("q_rsp_drop", 64'(rsp_valid), 64'd0);
        check("q_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("q_accepted", 64'(cmd_ready), 64'd0);
        check("q_new_adr", 64'(m_adr_o), 64'h5100);
        check("q_new_sel", 64'(m_sel_o), 64'h3C);
        check("q_setup2_cyc", 64'(m_cyc_o), 64'd0);
        @(negedge clk);
        check("q_access2_cyc", 64'(m_cyc_o), 64'd1);
        m_ack_i = 1'b1;
        m_dat_i = 64'h0000_0000_0000_00AB;
        @(negedge clk);
        m_ack_i = 1'b0;
        check("q_rsp2_dat", rsp_dat, 64'hAB);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Asynchronous reset during ACCESS
        cmd_we = 1'b0; cmd_adr = 32'h0000_6000; cmd_sel = 8'hFF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("r_access_cyc", 64'(m_cyc_o), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("r_cyc_async", 64'(m_cyc_o), 64'd0);
        check("r_stb_async", 64'(m_stb_o), 64'd0);
        check("r_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        check("r_cmd_ready", 64'(cmd_ready), 64'd1);
        check("r_no_rsp", 64'(rsp_valid), 64'd0);
        run_txn(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
